// File: rtl/carrd_wb_sequencer.sv
// Write-back sequencer: round-robin arbitration over functional-unit results and
// per-register (or single element) write beats. Optional CARRD_WB_SCOREBOARD_EN adds a pending-register scoreboard.
module carrd_wb_sequencer #(
  parameter int NUM_SRC  = 5,
  parameter int VLEN     = 128,
  parameter int MAX_LMUL = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*MAX_LMUL*VLEN-1:0] src_data,
  input  logic [NUM_SRC*5-1:0]         src_vd,
  input  logic [NUM_SRC*3-1:0]         src_nregs,
  input  logic [NUM_SRC-1:0]           src_el_mode,
  input  logic [NUM_SRC*5-1:0]         src_el_idx,
  output logic                         reg_wr_en,
  output logic [4:0]                   reg_wr_addr,
  output logic [VLEN-1:0]              reg_wr_data,
  output logic                         el_wr_en,
  output logic [4:0]                   el_reg_wr_addr,
  output logic [4:0]                   el_wr_addr,
  output logic [31:0]                  el_wr_data,
  output logic                         busy
`ifdef CARRD_WB_SCOREBOARD_EN
  ,
  input  logic [4:0]                   chk_addr,
  output logic [31:0]                  pending_mask,
  output logic                         chk_hazard
`endif
);

  localparam int GW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GRP = MAX_LMUL * VLEN;
  localparam logic [2:0] MAX_N = 3'(MAX_LMUL);

  // Handshake: a result transfers on a cycle where src_valid[i] && src_ready[i];
  // src_ready only rises in IDLE, for the single round-robin winner.
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic [GW-1:0]  last_grant;
  logic [GW-1:0]  grant_idx;
  logic           found;
  logic           accept;
  logic [GRP-1:0] sel_data;
  logic [GRP-1:0] data_q;
  logic [4:0]     sel_vd;
  logic [4:0]     sel_el_idx;
  logic [4:0]     vd_q;
  logic [2:0]     sel_nregs_raw;
  logic [2:0]     sel_n;
  logic [2:0]     n_q;
  logic [2:0]     beat;
  logic           sel_el_mode;
  logic           el_mode_q;
  int             k;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = (int'(last_grant) + 1 + i) % NUM_SRC;
      if (!found && src_valid[GW'(k)]) begin
        found     = 1'b1;
        grant_idx = GW'(k);
      end
    end
  end

  assign accept = (state == IDLE) && found;

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_data      = GRP'(src_data >> (GRP * int'(grant_idx)));
    sel_vd        = 5'(src_vd >> (5 * int'(grant_idx)));
    sel_el_idx    = 5'(src_el_idx >> (5 * int'(grant_idx)));
    sel_nregs_raw = 3'(src_nregs >> (3 * int'(grant_idx)));
    sel_el_mode   = src_el_mode[grant_idx];
    if (sel_nregs_raw == 3'd0)      sel_n = 3'd1;
    else if (sel_nregs_raw > MAX_N) sel_n = MAX_N;
    else                            sel_n = sel_nregs_raw;
  end

  // Beat 0 (or the element beat) is issued straight from the accept edge;
  // later beats come from the latched group, so src_* may change freely.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state          <= IDLE;
      last_grant     <= GW'(NUM_SRC - 1);
      data_q         <= '0;
      vd_q           <= '0;
      n_q            <= '0;
      el_mode_q      <= 1'b0;
      beat           <= '0;
      busy           <= 1'b0;
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      el_wr_en       <= 1'b0;
      el_reg_wr_addr <= '0;
      el_wr_addr     <= '0;
      el_wr_data     <= '0;
    end else begin
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      el_wr_en       <= 1'b0;
      el_reg_wr_addr <= '0;
      el_wr_addr     <= '0;
      el_wr_data     <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_q     <= sel_data;
            vd_q       <= sel_vd;
            n_q        <= sel_n;
            el_mode_q  <= sel_el_mode;
            last_grant <= grant_idx;
            beat       <= 3'd1;
            state      <= WRITE;
            busy       <= 1'b1;
            if (sel_el_mode) begin
              el_wr_en       <= 1'b1;
              el_reg_wr_addr <= sel_vd;
              el_wr_addr     <= sel_el_idx;
              el_wr_data     <= sel_data[31:0];
            end else begin
              reg_wr_en   <= 1'b1;
              reg_wr_addr <= sel_vd;
              reg_wr_data <= sel_data[VLEN-1:0];
            end
          end
        end
        WRITE: begin
          if (!el_mode_q && (beat < n_q)) begin
            reg_wr_en   <= 1'b1;
            reg_wr_addr <= vd_q + 5'(beat);
            reg_wr_data <= VLEN'(data_q >> (VLEN * int'(beat)));
            beat        <= beat + 3'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CARRD_WB_SCOREBOARD_EN
  logic [31:0] mask_new;

  always_comb begin
    mask_new = '0;
    if (sel_el_mode) begin
      mask_new[sel_vd] = 1'b1;
    end else begin
      for (int i = 0; i < MAX_LMUL; i++) begin
        if (3'(i) < sel_n) mask_new[5'(sel_vd + 5'(i))] = 1'b1;
      end
    end
  end

  // A bit drops at the end of the cycle whose strobe writes that register.
  always_ff @(posedge clk) begin
    if (nrst) begin
      pending_mask <= '0;
    end else if (accept) begin
      pending_mask <= mask_new;
    end else if (reg_wr_en) begin
      pending_mask[reg_wr_addr] <= 1'b0;
    end else if (el_wr_en) begin
      pending_mask[el_reg_wr_addr] <= 1'b0;
    end
  end

  assign chk_hazard = pending_mask[chk_addr];
`endif

endmodule

// File: doc/carrd_wb_sequencer.md
CARRD_WB_SEQUENCER -- requirements
Module: carrd_wb_sequencer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5; number of functional-unit result sources (ALU, MUL, LSU, SLDU, RED order).
REQ-002 SHALL have parameter VLEN, default 128; bits per vector register.
REQ-003 SHALL have parameter MAX_LMUL, default 4; maximum registers per result group.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1; rising-edge clock.
REQ-006 SHALL have port nrst, input, 1; synchronous active-high reset.
REQ-007 SHALL have port src_valid, input, NUM_SRC; per-source result valid.
REQ-008 SHALL have port src_ready, output, NUM_SRC; per-source accept; at most one bit high.
REQ-009 SHALL have port src_data, input, NUM_SRC*MAX_LMUL*VLEN; per-source result; register i of the group is slice i.
REQ-010 SHALL have port src_vd, input, NUM_SRC*5; base destination register.
REQ-011 SHALL have port src_nregs, input, NUM_SRC*3; registers in the group.
REQ-012 SHALL have port src_el_mode, input, NUM_SRC; 1 = scalar element write (reduction).
REQ-013 SHALL have port src_el_idx, input, NUM_SRC*5; element index for element writes.
REQ-014 SHALL have port reg_wr_en, output, 1; register write strobe.
REQ-015 SHALL have port reg_wr_addr, output, 5; register write address.
REQ-016 SHALL have port reg_wr_data, output, VLEN; register write data.
REQ-017 SHALL have port el_wr_en, output, 1; element write strobe.
REQ-018 SHALL have ports el_reg_wr_addr (output, 5) and el_wr_addr (output, 5); element register and element index.
REQ-019 SHALL have port el_wr_data, output, 32; element write data.
REQ-020 SHALL have port busy, output, 1; high while not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE and WRITE.
REQ-022 In IDLE, SHALL raise src_ready for exactly one valid source, chosen round-robin starting at last_grant+1 modulo NUM_SRC.
REQ-023 SHALL latch data, vd, nregs, el_mode and el_idx on src_valid&src_ready, update last_grant, and enter WRITE the next cycle.
REQ-024 SHALL hold src_ready low for all sources in WRITE; throughput is nregs+1 cycles per register-mode result and 2 cycles per element-mode result.
REQ-025 In register mode, SHALL assert reg_wr_en for nregs consecutive cycles, beat i writing slice i to address (vd+i) mod 32, with the first beat the cycle after accept.
REQ-026 SHALL treat nregs=0 as 1 and clamp nregs>MAX_LMUL to MAX_LMUL.
REQ-027 In element mode, SHALL assert el_wr_en for one cycle with el_reg_wr_addr=vd, el_wr_addr=el_idx and el_wr_data=slice0[31:0], keeping reg_wr_en low.
REQ-028 SHALL never assert reg_wr_en and el_wr_en in the same cycle.
REQ-029 SHALL return to IDLE after the last beat; a source valid at that point is granted in the following IDLE cycle.
REQ-030 SHALL drive all write strobes low and all write data/address outputs to 0 in IDLE.
REQ-031 SHALL ignore changes on src_* inputs after acceptance.

Reset
REQ-032 On nrst=1 at a clock edge, SHALL enter IDLE, set last_grant=NUM_SRC-1, and clear all outputs and latched fields to 0.
REQ-033 Reset during WRITE SHALL abort the group with no further write beats, and in-flight data SHALL be discarded.

Configuration
REQ-034 With CARRD_WB_SCOREBOARD_EN defined, SHALL add output pending_mask (32) marking the vector registers of the accepted group not yet written, set on accept, each bit cleared on its write beat, and reset to 0.
REQ-035 With CARRD_WB_SCOREBOARD_EN defined, SHALL add inputs chk_addr (5) and output chk_hazard (1) = pending_mask[chk_addr], combinational.
REQ-036 Without CARRD_WB_SCOREBOARD_EN, SHALL have neither port nor any scoreboard logic.

Verification
REQ-037 SHALL verify: src0 valid, vd=8, nregs=4 -> reg_wr_en for 4 cycles, addresses 8,9,10,11, slices 0..3; busy high for those 4 cycles.
REQ-038 SHALL verify: all 5 sources valid continuously, nregs=1 -> grant order 0,1,2,3,4,0, one every 2 cycles.
REQ-039 SHALL verify: src4 el_mode=1, vd=3, el_idx=7, slice0[31:0]=0xDEADBEEF -> single el_wr_en beat with that data; reg_wr_en stays 0.
REQ-040 SHALL verify: vd=30, nregs=4 -> addresses 30,31,0,1; with nregs=0 -> single beat; with nregs=7 -> 4 beats.
REQ-041 SHALL verify: nrst=1 on 2nd beat of a 4-register group -> no further strobes, IDLE next cycle, next grant goes to src0.
REQ-042 SHALL verify, with CARRD_WB_SCOREBOARD_EN: vd=4, nregs=2 accepted -> pending_mask=0x30, then 0x20, then 0x0; chk_addr=5 gives chk_hazard=1 until its beat.
